// File: rtl/pulse_stretcher_if.sv
// rtl/pulse_stretcher_if.sv - event/indication bundle between a trigger source and the pulse stretcher
interface pulse_stretcher_if #(
    parameter int QDEPTH = 3
);
    localparam int PW = $clog2(QDEPTH + 1);

    logic          trig;
    logic          out_level;
    logic          busy;
    logic [PW-1:0] pending;
    logic          drop;

    // Trigger source side
    modport master (
        output trig,
        input  out_level,
        input  busy,
        input  pending,
        input  drop
    );

    // Stretcher side
    modport slave (
        input  trig,
        output out_level,
        output busy,
        output pending,
        output drop
    );
endinterface

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches trig events into HOLD high / GAP low levels; PULSE_STRETCHER_QUEUE_EN enables event queueing
module pulse_stretcher #(
    parameter int HOLD_CYCLES = 1000,
    parameter int GAP_CYCLES  = 1000,
    parameter int QDEPTH      = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    pulse_stretcher_if.slave   bus
);
    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int PW   = $clog2(QDEPTH + 1);

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_level_q, out_level_d;
    logic          busy_q, busy_d;
    logic          drop_q, drop_d;

`ifdef PULSE_STRETCHER_QUEUE_EN
    localparam logic [PW-1:0] QMAX = PW'(QDEPTH);
    logic [PW-1:0] pending_q, pending_d;
`endif

    // Next-state, counter and output computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_level_d = out_level_q;
        busy_d      = busy_q;
        drop_d      = 1'b0;
`ifdef PULSE_STRETCHER_QUEUE_EN
        pending_d   = pending_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.trig) begin
                    state_d     = HOLD;
                    cnt_d       = HOLD_LOAD;
                    out_level_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            HOLD, GAP: begin
                if (state_q == GAP && cnt_q == '0) begin
`ifdef PULSE_STRETCHER_QUEUE_EN
                    // A trig here lands in the slot freed by this pop, so it is never dropped;
                    // with an empty queue the same trig is popped straight into the next hold.
                    if (pending_q != '0 || bus.trig) begin
                        state_d     = HOLD;
                        cnt_d       = HOLD_LOAD;
                        out_level_d = 1'b1;
                        if (!bus.trig) begin
                            pending_d = pending_q - PW'(1);
                        end
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
`else
                    drop_d  = bus.trig;
                    state_d = IDLE;
                    busy_d  = 1'b0;
`endif
                end else begin
                    if (cnt_q == '0) begin
                        state_d     = GAP;
                        cnt_d       = GAP_LOAD;
                        out_level_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
`ifdef PULSE_STRETCHER_QUEUE_EN
                    if (bus.trig) begin
                        if (pending_q < QMAX) begin
                            pending_d = pending_q + PW'(1);
                        end else begin
                            drop_d = 1'b1;
                        end
                    end
`else
                    drop_d = bus.trig;
`endif
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                out_level_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything including the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_level_q <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
`ifdef PULSE_STRETCHER_QUEUE_EN
            pending_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_level_q <= out_level_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
`ifdef PULSE_STRETCHER_QUEUE_EN
            pending_q   <= pending_d;
`endif
        end
    end

    assign bus.out_level = out_level_q;
    assign bus.busy      = busy_q;
    assign bus.drop      = drop_q;
`ifdef PULSE_STRETCHER_QUEUE_EN
    assign bus.pending   = pending_q;
`else
    assign bus.pending   = '0;
`endif
endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - directed self-checking bench for pulse_stretcher (HOLD=4, GAP=2, QDEPTH=2)
module tb_pulse_stretcher;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    pulse_stretcher_if #(.QDEPTH(2)) bus ();

    pulse_stretcher #(
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (2),
        .QDEPTH      (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare {out_level, busy, pending, drop} against an expected vector
    task automatic chk(input string tag, input logic eo, input logic eb,
                       input logic [1:0] ep, input logic ed);
        logic [4:0] obs;
        logic [4:0] exp;
        obs = {bus.out_level, bus.busy, bus.pending, bus.drop};
        exp = {eo, eb, ep, ed};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed(out,busy,pend,drop)=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive trig for one posedge, then check outputs at the following negedge
    task automatic tick(input logic t, input string tag, input logic eo, input logic eb,
                        input logic [1:0] ep, input logic ed);
        bus.trig = t;
        @(posedge clk);
        @(negedge clk);
        chk(tag, eo, eb, ep, ed);
    endtask

    task automatic do_reset();
        bus.trig = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("in_reset", 1'b0, 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises;
        logic prev;
        total    = 0;
        bad      = 0;
        bus.trig = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        do_reset();
        tick(1'b0, "idle_after_reset", 1'b0, 1'b0, 2'd0, 1'b0);

        // Single trig from IDLE: 4 high, 2 low, then idle
        tick(1'b1, "single_h1", 1'b1, 1'b1, 2'd0, 1'b0);
        tick(1'b0, "single_h2", 1'b1, 1'b1, 2'd0, 1'b0);
        tick(1'b0, "single_h3", 1'b1, 1'b1, 2'd0, 1'b0);
        tick(1'b0, "single_h4", 1'b1, 1'b1, 2'd0, 1'b0);
        tick(1'b0, "single_g1", 1'b0, 1'b1, 2'd0, 1'b0);
        tick(1'b0, "single_g2", 1'b0, 1'b1, 2'd0, 1'b0);
        tick(1'b0, "single_idle", 1'b0, 1'b0, 2'd0, 1'b0);
        tick(1'b0, "single_idle2", 1'b0, 1'b0, 2'd0, 1'b0);

        // Trig sampled on the final GAP cycle
        tick(1'b1, "gapend_h1", 1'b1, 1'b1, 2'd0, 1'b0);
        tick(1'b0, "gapend_h2", 1'b1, 1'b1, 2'd0, 1'b0);
        tick(1'b0, "gapend_h3", 1'b1, 1'b1, 2'd0, 1'b0);
        tick(1'b0, "gapend_h4", 1'b1, 1'b1, 2'd0, 1'b0);
        tick(1'b0, "gapend_g1", 1'b0, 1'b1, 2'd0, 1'b0);
        tick(1'b0, "gapend_g2", 1'b0, 1'b1, 2'd0, 1'b0);
`ifdef PULSE_STRETCHER_QUEUE_EN
        tick(1'b1, "gapend_rehold", 1'b1, 1'b1, 2'd0, 1'b0);
        tick(1'b0, "gapend_r2", 1'b1, 1'b1, 2'd0, 1'b0);
        tick(1'b0, "gapend_r3", 1'b1, 1'b1, 2'd0, 1'b0);
        tick(1'b0, "gapend_r4", 1'b1, 1'b1, 2'd0, 1'b0);
        tick(1'b0, "gapend_rg1", 1'b0, 1'b1, 2'd0, 1'b0);
        tick(1'b0, "gapend_rg2", 1'b0, 1'b1, 2'd0, 1'b0);
        tick(1'b0, "gapend_idle", 1'b0, 1'b0, 2'd0, 1'b0);

        // Trigs at n, n+2, n+3, n+4: queue fills to 2, fourth is dropped
        tick(1'b1, "q_t1", 1'b1, 1'b1, 2'd0, 1'b0);
        tick(1'b0, "q_t2", 1'b1, 1'b1, 2'd0, 1'b0);
        tick(1'b1, "q_t3", 1'b1, 1'b1, 2'd1, 1'b0);
        tick(1'b1, "q_t4", 1'b1, 1'b1, 2'd2, 1'b0);
        tick(1'b1, "q_t5_drop", 1'b0, 1'b1, 2'd2, 1'b1);
        tick(1'b0, "q_t6", 1'b0, 1'b1, 2'd2, 1'b0);
        tick(1'b0, "q_hold2", 1'b1, 1'b1, 2'd1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, $sformatf("q_h2_%0d", i), 1'b1, 1'b1, 2'd1, 1'b0);
        for (int i = 0; i < 2; i++) tick(1'b0, $sformatf("q_g2_%0d", i), 1'b0, 1'b1, 2'd1, 1'b0);
        tick(1'b0, "q_hold3", 1'b1, 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, $sformatf("q_h3_%0d", i), 1'b1, 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < 2; i++) tick(1'b0, $sformatf("q_g3_%0d", i), 1'b0, 1'b1, 2'd0, 1'b0);
        tick(1'b0, "q_idle", 1'b0, 1'b0, 2'd0, 1'b0);

        // Full queue plus trig on the pop cycle: restart, pending stays 2, no drop
        tick(1'b1, "co_t1", 1'b1, 1'b1, 2'd0, 1'b0);
        tick(1'b1, "co_t2", 1'b1, 1'b1, 2'd1, 1'b0);
        tick(1'b1, "co_t3", 1'b1, 1'b1, 2'd2, 1'b0);
        tick(1'b0, "co_h4", 1'b1, 1'b1, 2'd2, 1'b0);
        tick(1'b0, "co_g1", 1'b0, 1'b1, 2'd2, 1'b0);
        tick(1'b0, "co_g2", 1'b0, 1'b1, 2'd2, 1'b0);
        tick(1'b1, "co_pop_trig", 1'b1, 1'b1, 2'd2, 1'b0);
        tick(1'b0, "co_after", 1'b1, 1'b1, 2'd2, 1'b0);
        do_reset();

        // Trig held high 3 cycles: three holds total
        tick(1'b1, "lvl_t1", 1'b1, 1'b1, 2'd0, 1'b0);
        tick(1'b1, "lvl_t2", 1'b1, 1'b1, 2'd1, 1'b0);
        tick(1'b1, "lvl_t3", 1'b1, 1'b1, 2'd2, 1'b0);
        bus.trig = 1'b0;
        rises = 0;
        prev  = bus.out_level;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_level && !prev) rises++;
            prev = bus.out_level;
        end
        total++;
        assert (rises == 2) else begin
            bad++;
            $error("FAIL lvl_extra_holds observed=%0d expected=2", rises);
        end
        chk("lvl_idle", 1'b0, 1'b0, 2'd0, 1'b0);
`else
        tick(1'b1, "gapend_drop", 1'b0, 1'b0, 2'd0, 1'b1);
        tick(1'b0, "gapend_idle", 1'b0, 1'b0, 2'd0, 1'b0);

        // Trigs at n and n+2: one hold only, drop after n+2
        tick(1'b1, "nq_t1", 1'b1, 1'b1, 2'd0, 1'b0);
        tick(1'b0, "nq_t2", 1'b1, 1'b1, 2'd0, 1'b0);
        tick(1'b1, "nq_t3_drop", 1'b1, 1'b1, 2'd0, 1'b1);
        tick(1'b0, "nq_t4", 1'b1, 1'b1, 2'd0, 1'b0);
        tick(1'b0, "nq_g1", 1'b0, 1'b1, 2'd0, 1'b0);
        tick(1'b1, "nq_g2_drop", 1'b0, 1'b1, 2'd0, 1'b1);
        tick(1'b0, "nq_idle", 1'b0, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, $sformatf("nq_quiet_%0d", i), 1'b0, 1'b0, 2'd0, 1'b0);
`endif

        // Asynchronous reset mid-hold clears outputs without a clock edge
        tick(1'b1, "rst_h1", 1'b1, 1'b1, 2'd0, 1'b0);
`ifdef PULSE_STRETCHER_QUEUE_EN
        tick(1'b1, "rst_h2", 1'b1, 1'b1, 2'd1, 1'b0);
        tick(1'b0, "rst_h3", 1'b1, 1'b1, 2'd1, 1'b0);
`else
        tick(1'b1, "rst_h2", 1'b1, 1'b1, 2'd0, 1'b1);
        tick(1'b0, "rst_h3", 1'b1, 1'b1, 2'd0, 1'b0);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", 1'b0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick(1'b0, $sformatf("rst_no_replay_%0d", i), 1'b0, 1'b0, 2'd0, 1'b0);

        // First trig after release is taken at the next posedge
        tick(1'b1, "post_rst_h1", 1'b1, 1'b1, 2'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
